// File: rtl/countdown_gen.sv
// Loadable down-counter with one-shot/auto-reload, prescaler, hold and abort.
// Ports: Clk_i, Rst_n_i, Start_i, Load_val_i, Reload_i, Hold_i, Abort_i -> Count_o, Busy_o, Done_o, Zero_o.
module countdown_gen #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             Clk_i,
  input  logic             Rst_n_i,
  input  logic             Start_i,
  input  logic [WIDTH-1:0] Load_val_i,
  input  logic             Reload_i,
  input  logic             Hold_i,
  input  logic             Abort_i,
  output logic [WIDTH-1:0] Count_o,
  output logic             Busy_o,
  output logic             Done_o,
  output logic             Zero_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             rld_q, rld_d;
  logic             done_q, done_d;

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      val_q   <= '0;
      presc_q <= '0;
      rld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      val_q   <= val_d;
      presc_q <= presc_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    val_d   = val_q;
    presc_d = presc_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
    if (Abort_i) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start_i) begin
            if (Load_val_i != '0) begin
              count_d = Load_val_i;
              val_d   = Load_val_i;
              rld_d   = Reload_i;
              presc_d = '0;
              state_d = RUN;
            end else begin
              // zero load: immediate Done, never enters RUN
              done_d = 1'b1;
            end
          end
        end
        RUN, HOLD: begin
          if (Hold_i) begin
            state_d = HOLD;
          end else begin
            // leaving HOLD counts in the same cycle as RUN would
            state_d = RUN;
            if (count_q == '0) begin
              // reload cycle after terminal count (auto-reload only)
              count_d = val_q;
              presc_d = '0;
            end else if (presc_q == PMAX) begin
              presc_d = '0;
              count_d = count_q - WIDTH'(1);
              if (count_q == WIDTH'(1)) begin
                done_d = 1'b1;
                if (!rld_q) state_d = IDLE;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  assign Count_o = count_q;
  assign Busy_o  = (state_q != IDLE);
  assign Done_o  = done_q;
  assign Zero_o  = (count_q == '0);

endmodule

// File: tb/tb_countdown_gen.sv
// Directed self-checking bench for countdown_gen.
// Two instances: PRESCALE=1 (d1) and PRESCALE=3 (d3) share stimulus.
module tb_countdown_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] load;
  logic       reload;
  logic       hold;
  logic       abort;

  logic [3:0] c1, c3;
  logic       b1, b3, dn1, dn3, z1, z3;

  int n_cmp = 0;
  int n_err = 0;

  countdown_gen #(.WIDTH(4), .PRESCALE(1)) d1 (
    .Clk_i(clk), .Rst_n_i(rst_n), .Start_i(start), .Load_val_i(load),
    .Reload_i(reload), .Hold_i(hold), .Abort_i(abort),
    .Count_o(c1), .Busy_o(b1), .Done_o(dn1), .Zero_o(z1)
  );

  countdown_gen #(.WIDTH(4), .PRESCALE(3)) d3 (
    .Clk_i(clk), .Rst_n_i(rst_n), .Start_i(start), .Load_val_i(load),
    .Reload_i(reload), .Hold_i(hold), .Abort_i(abort),
    .Count_o(c3), .Busy_o(b3), .Done_o(dn3), .Zero_o(z3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input int cnt, input int bsy,
                      input int dn);
    chk({tag, ".count"}, 32'(c1), 32'(cnt));
    chk({tag, ".busy"}, 32'(b1), 32'(bsy));
    chk({tag, ".done"}, 32'(dn1), 32'(dn));
    chk({tag, ".zero"}, 32'(z1), 32'(cnt == 0));
  endtask

  int seq_c[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
  int seq_d[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
  int p3_c[6]  = '{2, 2, 1, 1, 1, 0};

  initial begin
    rst_n = 1'b0; start = 1'b0; load = '0;
    reload = 1'b0; hold = 1'b0; abort = 1'b0;
    #3;
    chk1("reset", 0, 0, 0);
    chk("reset.d3count", 32'(c3), 32'd0);
    tick();
    rst_n = 1'b1;

    // 1: one-shot load 5
    start = 1'b1; load = 4'd5;
    tick();
    start = 1'b0;
    chk1("t1.load", 5, 1, 0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk1("t1.run", i, 1, 0);
    end
    tick();
    chk1("t1.term", 0, 0, 1);
    tick();
    chk1("t1.after", 0, 0, 0);

    // 2: zero load
    start = 1'b1; load = 4'd0; reload = 1'b1;
    tick();
    start = 1'b0; reload = 1'b0;
    chk1("t2.done", 0, 0, 1);
    tick();
    chk1("t2.after", 0, 0, 0);

    // 3: auto-reload, period N+1
    start = 1'b1; load = 4'd3; reload = 1'b1;
    tick();
    start = 1'b0; reload = 1'b0; load = 4'd9;
    chk1("t3.load", 3, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("t3.seq", seq_c[i], 1, seq_d[i]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("t3.abort", 0, 0, 0);

    // 4: prescaler 3
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    start = 1'b1; load = 4'd2; reload = 1'b0;
    tick();
    start = 1'b0;
    chk("t4.load", 32'(c3), 32'd2);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4.count", 32'(c3), 32'(p3_c[i]));
      chk("t4.done", 32'(dn3), 32'(i == 5));
      chk("t4.busy", 32'(b3), 32'(i != 5));
    end

    // 5: hold for two cycles at count 3
    tick();
    start = 1'b1; load = 4'd6;
    tick();
    start = 1'b0;
    chk1("t5.load", 6, 1, 0);
    for (int i = 5; i >= 3; i--) begin
      tick();
      chk1("t5.run", i, 1, 0);
    end
    hold = 1'b1;
    tick();
    chk1("t5.hold1", 3, 1, 0);
    tick();
    chk1("t5.hold2", 3, 1, 0);
    hold = 1'b0;
    tick();
    chk1("t5.res2", 2, 1, 0);
    tick();
    chk1("t5.res1", 1, 1, 0);
    tick();
    chk1("t5.term", 0, 0, 1);

    // 6: abort beats start; async reset
    start = 1'b1; load = 4'd5;
    tick();
    start = 1'b0;
    for (int i = 4; i >= 2; i--) begin
      tick();
      chk1("t6.run", i, 1, 0);
    end
    abort = 1'b1; start = 1'b1; load = 4'd7;
    tick();
    abort = 1'b0; start = 1'b0;
    chk1("t6.abort", 0, 0, 0);
    tick();
    chk1("t6.idle", 0, 0, 0);
    start = 1'b1; load = 4'd4;
    tick();
    start = 1'b0;
    chk1("t6.load4", 4, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("t6.async", 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk1("t6.post", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_gen.md
Name: countdown_gen

Overview:
Loadable down-counter that produces a WIDTH-bit count sequence ending at zero, with a one-cycle Done pulse at terminal count. It is the source side of the team's zero-detect logic: it generates the values a zero detector consumes, and it also exports its own Zero flag. Used as a programmable delay or interval timer. It supports one-shot and auto-reload modes, a prescaler, hold and abort.

Parameters:
WIDTH, 4, count and load-value width in bits
PRESCALE, 1, clock cycles per decrement; legal values >= 1

Ports:
Clk  input  1  system clock, all state updates on the rising edge
Rst_n  input  1  asynchronous active-low reset
Start  input  1  load Load_val and begin counting; honoured only in IDLE
Load_val  input  WIDTH  initial count, sampled on the Start edge
Reload  input  1  auto-reload mode, sampled and latched on the Start edge
Hold  input  1  freeze count and prescaler while high
Abort  input  1  cancel the operation and return to IDLE
Count  output  WIDTH  current count, registered
Busy  output  1  high when state is not IDLE, registered
Done  output  1  one-cycle pulse on reaching terminal count, registered
Zero  output  1  combinational (Count == 0) from the registered Count

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE, Count=0, Busy=0, Done=0, prescaler=0, reload latch=0, reload-value latch=0. Zero=1 follows from Count=0.
- Reset applied mid-operation: immediate return to reset values. No Done is issued.
- Done defaults to 0 every cycle unless it is set by a rule below.
- States: IDLE, RUN, HOLD. Busy=1 exactly when in RUN or HOLD.
- IDLE:
  - Start=1 and Load_val!=0: Count<=Load_val, latch Load_val and Reload, prescaler<=0, go to RUN.
  - Start=1 and Load_val==0: Done<=1 on the next edge, stay in IDLE, Busy stays 0. This applies regardless of Reload, so a zero load can never cause an endless reload loop.
- RUN:
  - The prescaler counts 0..PRESCALE-1. On the cycle where prescaler==PRESCALE-1 (the tick), Count<=Count-1 and the prescaler wraps to 0.
  - With PRESCALE=1, every cycle is a tick.
- Terminal tick (tick while Count==1): Count<=0 and Done<=1 on the same edge.
  - Reload=0: go to IDLE on that edge; Busy falls together with Done rising.
  - Reload=1: stay in RUN. Count sits at 0 for exactly one cycle, then Count<=latched value and the prescaler restarts at 0. The reload cycle does not decrement.
- Latency: a Start sampled at edge k with Load_val=N gives Count=N after edge k. With PRESCALE=1, Done is high after edge k+N. In general Done occurs N*PRESCALE cycles after the load.
- Reload period: with PRESCALE=1, Done pulses every N+1 cycles.
- Hold=1 in RUN: go to HOLD on the next edge; Count and prescaler are frozen. A tick that coincides with Hold=1 is suppressed.
- HOLD: Hold=0 returns to RUN, and counting resumes from the frozen prescaler value.
- Abort=1 in any state: on the next edge Count<=0, prescaler<=0, go to IDLE, Busy<=0, Done stays 0.
- Priority: Abort > Hold > tick. Abort and Start in the same cycle: Abort wins and Start is ignored.
- Start while in RUN or HOLD: ignored. Load_val and Reload changes after the Start edge have no effect.
- Arithmetic: Count is unsigned and never decrements below 0. There is no wrap-around.

Test Plan:
1. PRESCALE=1, Start with Load_val=5, Reload=0 -> Count 5,4,3,2,1,0 on consecutive edges. Done=1 for one cycle with Count=0, 5 cycles after the load. Busy falls on the same edge. Zero=1 afterwards.
2. Start with Load_val=0 -> Done=1 one edge later for one cycle. Busy stays 0 and Count stays 0.
3. Reload=1, Load_val=3 -> Count 3,2,1,0,3,2,1,0,3... Done pulses every 4 cycles, each coinciding with Count=0. Busy stays 1.
4. PRESCALE=3, Load_val=2 -> Count holds 2 for 3 cycles, 1 for 3 cycles, then 0. Done arrives 6 cycles after the load.
5. PRESCALE=1, Load_val=6, Hold high for 2 cycles while Count=3 -> Count stays 3 through HOLD. Done arrives 8 cycles after the load instead of 6.
6. Abort with Start high in the same cycle while Count=2 -> next edge Count=0, Busy=0, Done never pulses. Separately, Rst_n low while Count=4 -> outputs go to reset values immediately, without waiting for a clock edge.
